wb_queue: RTL
=============

# wb_queue

Writeback queue on the producer side of the 32x32 register file write port. Accepts register-write requests from two producers (port A: ALU, port B: load unit) over valid/ready handshakes, buffers them in a small in-order FIFO, and drains one entry per cycle onto the register file's rd/dataIn/writeEn port. While writes are still queued, it provides youngest-match forwarding for the two read addresses (rs1, rs2) so the datapath never reads stale register values.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- WIDTH, 32, data width; matches register file
- clk  in  1  clock; all state updates on rising edge
- r  in  1  reset; asynchronous, active-high
- a_valid  in  1  port A write request
- a_ready  out  1  port A accepted this cycle
- a_rd  in  5  port A destination register
- a_data  in  WIDTH  port A write data
- b_valid  in  1  port B write request
- b_ready  out  1  port B accepted this cycle
- b_rd  in  5  port B destination register
- b_data  in  WIDTH  port B write data
- hold  in  1  suppress draining; port is lent elsewhere
- wr_en  out  1  to register file writeEn
- wr_rd  out  5  to register file rd
- wr_data  out  WIDTH  to register file dataIn
- rs1, rs2  in  5 each  read addresses currently presented to the register file
- fwd_a_hit, fwd_b_hit  out  1 each  queued write pending for rs1 / rs2
- fwd_a_data, fwd_b_data  out  WIDTH each  youngest queued data for rs1 / rs2
- count  out  clog2(DEPTH)+1  occupied entries
- full, empty  out  1 each  count==DEPTH / count==0

## Operation
- Storage: circular buffer of DEPTH entries {rd, data}, with head pointer, tail pointer and count register.
- Arbitration: fixed priority, A over B, at most one enqueue per cycle.
  - a_ready = !full.
  - b_ready = !full && !a_valid.
- Handshake: the transfer occurs at the edge where valid && ready. The producer holds rd/data stable while valid && !ready. The queue never drops a request that is waiting.
- x0 filtering: an accepted request with rd==0 completes its handshake but is not enqueued; count is unchanged.
- Drain (combinational from head):
  - wr_en = !empty && !hold.
  - wr_rd/wr_data = head entry whenever !empty; 0 when empty.
  - Pop at the edge where wr_en=1.
- Simultaneous enqueue and pop: count is unchanged, and both pointers advance modulo DEPTH.
- Full: no enqueue is accepted, even if a pop occurs in the same cycle. Ready is computed from the registered count only.
- Forwarding (combinational):
  - Scan all valid entries for rd==rs1 (and, separately, rd==rs2).
  - The youngest match (closest to tail) wins.
  - hit=0 and data=0 when there is no match or rs==0.
  - The head entry being written this cycle is still a hit.
  - An entry enqueued at this edge is visible from the next cycle.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0; forwarding age ordering is correct across the wrap.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - head=tail=count=0; empty=1, full=0, wr_en=0, wr_rd=0, wr_data=0.
  - a_ready=1, and b_ready=!a_valid.
  - Forwarding hits=0.
- Reset mid-operation: all queued writes are discarded. No writeEn pulse occurs after r rises.
- Latency: a request accepted at edge N, with an empty queue and hold=0, is written to the register file at edge N+1 (wr_en high during cycle N..N+1).
- Throughput: 1 write per cycle sustained with hold=0. The queue fills only under hold.
- hold rising mid-stream: wr_en drops in the same cycle, and the head entry stays in place. No entry is lost or duplicated.
- Forwarding outputs settle within the same cycle as rs1/rs2 change. There is no registered stage.

## Test plan
- Reset, then A writes rd=5 data=0xDEADBEEF -> a_ready=1, count=1 next cycle; wr_en=1, wr_rd=5, wr_data=0xDEADBEEF for one cycle; empty=1 after.
- hold=1, A and B both valid every cycle with distinct rd 1..8 -> only A accepted while a_valid; full=1 after 4 accepts, a_ready=b_ready=0; release hold -> 4 writes drain in acceptance order, one per cycle.
- hold=1; queue rd=7 data=0x11, then rd=7 data=0x22; rs1=7, rs2=3 -> fwd_a_hit=1, fwd_a_data=0x22; fwd_b_hit=0, fwd_b_data=0.
- A writes rd=0 data=0xFFFFFFFF -> handshake completes, count stays 0, wr_en never asserts; rs1=0 -> fwd_a_hit=0.
- Stream 10 writes with hold toggling every third cycle -> pointers wrap; register file writes match accepted order exactly; forwarding returns youngest data across the wrap.
- Queue 3 entries under hold, assert r mid-cycle -> wr_en=0, count=0, empty=1 immediately; after release, no stale writes appear.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: writeback queue feeding the register file write port.
// Two producers (A = ALU, B = load unit, A has priority) enqueue {rd, data}
// into an in-order circular buffer that drains one entry per cycle unless
// hold is asserted. Queued writes are forwarded to the rs1/rs2 read ports,
// youngest match first, so the datapath never sees a stale register value.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     r,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4:0]               a_rd,
  input  logic [WIDTH-1:0]         a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_rd,
  input  logic [WIDTH-1:0]         b_data,
  input  logic                     hold,
  output logic                     wr_en,
  output logic [4:0]               wr_rd,
  output logic [WIDTH-1:0]         wr_data,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     fwd_a_hit,
  output logic                     fwd_b_hit,
  output logic [WIDTH-1:0]         fwd_a_data,
  output logic [WIDTH-1:0]         fwd_b_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]       mem_rd   [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  logic             take_a;
  logic             take_b;
  logic [4:0]       enq_rd;
  logic [WIDTH-1:0] enq_data;
  logic             push;
  logic             pop;

  // Status and handshake; ready depends only on the registered count, so a
  // same-cycle pop never opens a slot for a full queue.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign a_ready = !full;
  assign b_ready = !full && !a_valid;

  assign take_a   = a_valid && a_ready;
  assign take_b   = b_valid && b_ready;
  assign enq_rd   = take_a ? a_rd : b_rd;
  assign enq_data = take_a ? a_data : b_data;
  // Writes to x0 complete the handshake but are dropped here.
  assign push     = (take_a || take_b) && (enq_rd != 5'd0);

  // Drain port is driven straight from the head entry.
  assign wr_en   = !empty && !hold;
  assign pop     = wr_en;
  assign wr_rd   = empty ? '0 : mem_rd[head];
  assign wr_data = empty ? '0 : mem_data[head];

  // Pointer and occupancy registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the entry array has no reset; an entry is only ever observed when
  // it lies within count of head, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[tail]   <= enq_rd;
      mem_data[tail] <= enq_data;
    end
  end

  // Forwarding: walk valid entries oldest to youngest so the youngest match
  // is the one left standing; the head entry being written still counts.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a value held, which would otherwise infer a latch.
    logic [AW-1:0] idx;
    fwd_a_hit  = 1'b0;
    fwd_b_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_data = '0;
    idx        = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count) begin
        if ((rs1 != 5'd0) && (mem_rd[idx] == rs1)) begin
          fwd_a_hit  = 1'b1;
          fwd_a_data = mem_data[idx];
        end
        if ((rs2 != 5'd0) && (mem_rd[idx] == rs2)) begin
          fwd_b_hit  = 1'b1;
          fwd_b_data = mem_data[idx];
        end
      end
    end
  end

endmodule
